// File: rtl/eth_tx_hdr_builder.sv
// Store-and-forward TX header builder: buffers each MFB frame, measures it and emits the
// 25-bit {discard, port, length} header alongside the SOF word. ETH_TX_HDR_BUILDER_STATS_EN adds counters.
module eth_tx_hdr_builder #(
  parameter int unsigned REGION_SIZE = 8,
  parameter int unsigned BLOCK_SIZE  = 8,
  parameter int unsigned ITEM_WIDTH  = 8,
  parameter int unsigned TX_MTU      = 16383,
  parameter int unsigned LEN_MIN     = 60,
  parameter int unsigned DATA_DEPTH  = 512,
  parameter int unsigned HDR_DEPTH   = 16,
  localparam int unsigned WB  = REGION_SIZE * BLOCK_SIZE,
  localparam int unsigned DW  = WB * ITEM_WIDTH,
  localparam int unsigned SPW = (REGION_SIZE > 1) ? $clog2(REGION_SIZE) : 1,
  localparam int unsigned EPW = $clog2(WB)
) (
  input  logic           CLK,
  input  logic           RESET_N,
  input  logic [DW-1:0]  RX_DATA,
  input  logic [SPW-1:0] RX_SOF_POS,
  input  logic [EPW-1:0] RX_EOF_POS,
  input  logic           RX_SOF,
  input  logic           RX_EOF,
  input  logic [7:0]     RX_PORT,
  input  logic           RX_SRC_RDY,
  output logic           RX_DST_RDY,
  output logic [DW-1:0]  TX_DATA,
  output logic [SPW-1:0] TX_SOF_POS,
  output logic [EPW-1:0] TX_EOF_POS,
  output logic           TX_SOF,
  output logic           TX_EOF,
  output logic [24:0]    TX_HDR,
  output logic           TX_SRC_RDY,
  input  logic           TX_DST_RDY
`ifdef ETH_TX_HDR_BUILDER_STATS_EN
  ,
  input  logic           STAT_CLR,
  output logic [31:0]    STAT_FRAMES,
  output logic [31:0]    STAT_DISCARDS
`endif
);

  localparam int unsigned DAW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
  localparam int unsigned HAW = (HDR_DEPTH > 1) ? $clog2(HDR_DEPTH) : 1;
  localparam int unsigned DCW = $clog2(DATA_DEPTH + 1);
  localparam int unsigned HCW = $clog2(HDR_DEPTH + 1);

  typedef struct packed {
    logic [DW-1:0]  data;
    logic [SPW-1:0] sof_pos;
    logic [EPW-1:0] eof_pos;
    logic           sof;
    logic           eof;
  } word_t;

  typedef enum logic [1:0] {StIdle, StFrame, StDrop} state_e;

  function automatic logic [16:0] sat_add(input logic [16:0] a, input logic [16:0] b);
    logic [17:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[17] ? 17'h1ffff : s[16:0];
  endfunction

  function automatic logic [15:0] cap16(input logic [16:0] v);
    return v[16] ? 16'hffff : v[15:0];
  endfunction

  state_e      state_q, state_d;
  logic [16:0] acc_q, acc_d;
  logic [7:0]  port_q, port_d;
  logic        rx_rdy_q, rx_rdy_d;

  logic        hdr_stg_vld_q;
  logic [24:0] hdr_stg_q;

  word_t          data_mem [DATA_DEPTH];
  logic [DAW-1:0] data_wr_q, data_rd_q;
  logic [DCW-1:0] data_cnt_q, data_cnt_d;

  logic [24:0]    hdr_mem [HDR_DEPTH];
  logic [HAW-1:0] hdr_wr_q, hdr_rd_q;
  logic [HCW-1:0] hdr_cnt_q, hdr_cnt_d;

  logic        rx_fire, tx_fire, hdr_pop;
  logic        wr_en, hdr_push, hdr_trunc;
  logic [16:0] hdr_len, sof_off, eof_bytes, step, nxt;
  logic [7:0]  hdr_port;
  logic [24:0] hdr_word;
  word_t       wr_word, head;
  logic        data_empty, hdr_empty, tx_vld;

  assign rx_fire   = RX_SRC_RDY && rx_rdy_q;
  assign sof_off   = 17'(32'(RX_SOF_POS) * BLOCK_SIZE);
  assign eof_bytes = 17'(RX_EOF_POS) + 17'd1;

  // Input FSM: measures the frame and decides what gets written to the data FIFO
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    port_d    = port_q;
    wr_en     = 1'b0;
    wr_word   = '{data: RX_DATA, sof_pos: RX_SOF_POS, eof_pos: RX_EOF_POS,
                  sof: RX_SOF, eof: RX_EOF};
    hdr_push  = 1'b0;
    hdr_trunc = 1'b0;
    hdr_len   = '0;
    hdr_port  = port_q;
    step      = RX_EOF ? eof_bytes : 17'(WB);
    nxt       = sat_add(acc_q, step);
    if (rx_fire) begin
      unique case (state_q)
        StIdle: begin
          if (RX_SOF) begin
            wr_en    = 1'b1;
            port_d   = RX_PORT;
            hdr_port = RX_PORT;
            if (RX_EOF) begin
              hdr_push = 1'b1;
              hdr_len  = eof_bytes - sof_off;
            end else begin
              acc_d   = 17'(WB) - sof_off;
              state_d = StFrame;
            end
          end
        end
        StFrame: begin
          wr_en = 1'b1;
          if (nxt > 17'(TX_MTU)) begin
            // Oversize: close the frame on this word and flag it for discard downstream
            wr_word.eof     = 1'b1;
            wr_word.eof_pos = EPW'(WB - 1);
            hdr_push        = 1'b1;
            hdr_trunc       = 1'b1;
            hdr_len         = sat_add(acc_q, 17'(WB));
            state_d         = RX_EOF ? StIdle : StDrop;
          end else if (RX_EOF) begin
            hdr_push = 1'b1;
            hdr_len  = nxt;
            state_d  = StIdle;
          end else begin
            acc_d = nxt;
          end
        end
        StDrop: begin
          if (RX_EOF) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign hdr_word = {hdr_trunc || (hdr_len < 17'(LEN_MIN)), hdr_port, cap16(hdr_len)};

  // FWFT output side; the SOF word waits until its header has landed in the header FIFO
  assign head       = data_mem[data_rd_q];
  assign data_empty = (data_cnt_q == '0);
  assign hdr_empty  = (hdr_cnt_q == '0);
  assign tx_vld     = !data_empty && (!head.sof || !hdr_empty);
  assign tx_fire    = tx_vld && TX_DST_RDY;
  assign hdr_pop    = tx_fire && head.sof;

  assign TX_SRC_RDY = tx_vld;
  assign TX_DATA    = data_empty ? '0 : head.data;
  assign TX_SOF_POS = data_empty ? '0 : head.sof_pos;
  assign TX_EOF_POS = data_empty ? '0 : head.eof_pos;
  assign TX_SOF     = !data_empty && head.sof;
  assign TX_EOF     = !data_empty && head.eof;
  assign TX_HDR     = hdr_empty ? '0 : hdr_mem[hdr_rd_q];
  assign RX_DST_RDY = rx_rdy_q;

  always_comb begin
    data_cnt_d = data_cnt_q;
    if (wr_en && !tx_fire) begin
      data_cnt_d = data_cnt_q + 1'b1;
    end else if (!wr_en && tx_fire) begin
      data_cnt_d = data_cnt_q - 1'b1;
    end
    hdr_cnt_d = hdr_cnt_q;
    if (hdr_stg_vld_q && !hdr_pop) begin
      hdr_cnt_d = hdr_cnt_q + 1'b1;
    end else if (!hdr_stg_vld_q && hdr_pop) begin
      hdr_cnt_d = hdr_cnt_q - 1'b1;
    end
    // The staged header counts as occupied so the FIFO can never overflow
    rx_rdy_d = (state_d == StDrop) ||
               ((data_cnt_d != DCW'(DATA_DEPTH)) &&
                ((32'(hdr_cnt_d) + 32'(hdr_push)) < HDR_DEPTH));
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q       <= StIdle;
      acc_q         <= '0;
      port_q        <= '0;
      rx_rdy_q      <= 1'b0;
      hdr_stg_vld_q <= 1'b0;
      hdr_stg_q     <= '0;
      data_wr_q     <= '0;
      data_rd_q     <= '0;
      data_cnt_q    <= '0;
      hdr_wr_q      <= '0;
      hdr_rd_q      <= '0;
      hdr_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      port_q        <= port_d;
      rx_rdy_q      <= rx_rdy_d;
      hdr_stg_vld_q <= hdr_push;
      if (hdr_push) hdr_stg_q <= hdr_word;
      data_cnt_q    <= data_cnt_d;
      hdr_cnt_q     <= hdr_cnt_d;
      if (wr_en) begin
        data_wr_q <= (data_wr_q == DAW'(DATA_DEPTH - 1)) ? '0 : data_wr_q + 1'b1;
      end
      if (tx_fire) begin
        data_rd_q <= (data_rd_q == DAW'(DATA_DEPTH - 1)) ? '0 : data_rd_q + 1'b1;
      end
      if (hdr_stg_vld_q) begin
        hdr_wr_q <= (hdr_wr_q == HAW'(HDR_DEPTH - 1)) ? '0 : hdr_wr_q + 1'b1;
      end
      if (hdr_pop) begin
        hdr_rd_q <= (hdr_rd_q == HAW'(HDR_DEPTH - 1)) ? '0 : hdr_rd_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) data_mem[data_wr_q] <= wr_word;
    if (hdr_stg_vld_q) hdr_mem[hdr_wr_q] <= hdr_stg_q;
  end

`ifdef ETH_TX_HDR_BUILDER_STATS_EN
  logic [31:0] stat_frames_q, stat_discards_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      stat_frames_q   <= '0;
      stat_discards_q <= '0;
    end else if (STAT_CLR) begin
      stat_frames_q   <= '0;
      stat_discards_q <= '0;
    end else if (hdr_push) begin
      if (stat_frames_q != '1) stat_frames_q <= stat_frames_q + 1'b1;
      if (hdr_word[24] && (stat_discards_q != '1)) stat_discards_q <= stat_discards_q + 1'b1;
    end
  end

  assign STAT_FRAMES   = stat_frames_q;
  assign STAT_DISCARDS = stat_discards_q;
`endif

endmodule

// File: tb/tb_eth_tx_hdr_builder.sv
// Directed + randomized bench for eth_tx_hdr_builder with a frame-level reference model.
module tb_eth_tx_hdr_builder;
  localparam int DW   = 512;
  localparam int MTU  = 16383;
  localparam int LMIN = 60;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sof;
    logic          eof;
    logic [2:0]    sp;
    logic [5:0]    ep;
    logic [24:0]   hdr;
  } exp_t;

  logic          CLK = 1'b0;
  logic          RESET_N;
  logic [DW-1:0] RX_DATA;
  logic [2:0]    RX_SOF_POS;
  logic [5:0]    RX_EOF_POS;
  logic          RX_SOF, RX_EOF;
  logic [7:0]    RX_PORT;
  logic          RX_SRC_RDY, RX_DST_RDY;
  logic [DW-1:0] TX_DATA;
  logic [2:0]    TX_SOF_POS;
  logic [5:0]    TX_EOF_POS;
  logic          TX_SOF, TX_EOF;
  logic [24:0]   TX_HDR;
  logic          TX_SRC_RDY, TX_DST_RDY;
`ifdef ETH_TX_HDR_BUILDER_STATS_EN
  logic          STAT_CLR;
  logic [31:0]   STAT_FRAMES, STAT_DISCARDS;
`endif

  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  logic rand_bp = 1'b0;
  logic gaps_en = 1'b0;

  always #5 CLK = ~CLK;

  eth_tx_hdr_builder dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .RX_DATA    (RX_DATA),
    .RX_SOF_POS (RX_SOF_POS),
    .RX_EOF_POS (RX_EOF_POS),
    .RX_SOF     (RX_SOF),
    .RX_EOF     (RX_EOF),
    .RX_PORT    (RX_PORT),
    .RX_SRC_RDY (RX_SRC_RDY),
    .RX_DST_RDY (RX_DST_RDY),
    .TX_DATA    (TX_DATA),
    .TX_SOF_POS (TX_SOF_POS),
    .TX_EOF_POS (TX_EOF_POS),
    .TX_SOF     (TX_SOF),
    .TX_EOF     (TX_EOF),
    .TX_HDR     (TX_HDR),
    .TX_SRC_RDY (TX_SRC_RDY),
    .TX_DST_RDY (TX_DST_RDY)
`ifdef ETH_TX_HDR_BUILDER_STATS_EN
    ,
    .STAT_CLR      (STAT_CLR),
    .STAT_FRAMES   (STAT_FRAMES),
    .STAT_DISCARDS (STAT_DISCARDS)
`endif
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd512();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Called #1 after a posedge; returns #1 after the edge that accepted the word
  task automatic send_word(input logic [DW-1:0] d, input logic sof, input logic eof,
                           input logic [2:0] sp, input logic [5:0] ep, input logic [7:0] port);
    int   k = 0;
    logic acc;
    RX_DATA = d; RX_SOF = sof; RX_EOF = eof; RX_SOF_POS = sp; RX_EOF_POS = ep; RX_PORT = port;
    RX_SRC_RDY = 1'b1;
    forever begin
      @(negedge CLK);
      acc = RX_DST_RDY;
      @(posedge CLK); #1;
      if (rand_bp) TX_DST_RDY = ($urandom_range(3) != 0);
      if (acc) break;
      k++;
      if (k > 5000) begin
        n_vec++; n_err++;
        $error("FAIL rx_accept_timeout: observed RX_DST_RDY=0 for %0d cycles expected 1", k);
        break;
      end
    end
    RX_SRC_RDY = 1'b0;
    if (gaps_en && ($urandom_range(3) == 0)) begin
      @(posedge CLK); #1;
      if (rand_bp) TX_DST_RDY = ($urandom_range(3) != 0);
    end
  endtask

  // Reference: frame of len bytes starting at block sb; oversize frames are cut at the first
  // word whose end lies beyond the MTU, reporting bytes up to that word's end.
  task automatic send_frame(input int len, input int sb, input logic [7:0] port);
    int          start, nw, lastep, k, cum;
    logic [24:0] h;
    logic [15:0] hl;
    exp_t        w;
    logic [DW-1:0] d;
    logic        sof, eof;
    logic [2:0]  sp;
    logic [5:0]  ep;
    start  = sb * 8;
    nw     = (start + len + 63) / 64;
    lastep = (start + len - 1) % 64;
    k      = 0;
    for (int j = 1; j <= nw; j++) begin
      cum = (j == nw) ? len : 64 * j - start;
      if (k == 0 && cum > MTU) k = j;
    end
    if (k != 0) begin
      cum = 64 * k - start;
      hl  = (cum > 65535) ? 16'hffff : 16'(cum);
      h   = {1'b1, port, hl};
    end else begin
      h = {(len < LMIN) ? 1'b1 : 1'b0, port, 16'(len)};
    end
    for (int j = 1; j <= nw; j++) begin
      d   = rnd512();
      sof = (j == 1);
      eof = (j == nw);
      sp  = sof ? 3'(sb) : 3'($urandom);
      ep  = eof ? 6'(lastep) : 6'($urandom);
      if (k == 0 || j <= k) begin
        w.data = d; w.sof = sof; w.sp = sp; w.hdr = h;
        w.eof  = (k != 0 && j == k) ? 1'b1 : eof;
        w.ep   = (k != 0 && j == k) ? 6'd63 : ep;
        exp_q.push_back(w);
      end
      send_word(d, sof, eof, sp, ep, sof ? port : 8'($urandom));
    end
  endtask

  task automatic wait_drain(input string tag);
    int k = 0;
    TX_DST_RDY = 1'b1;
    while ((exp_q.size() != 0 || TX_SRC_RDY) && k < 5000) begin
      @(posedge CLK); #1;
      k++;
    end
    check({tag, "_pending_words"}, DW'(exp_q.size()), '0);
  endtask

  initial begin
    int sb, len;
    RESET_N = 1'b0; RX_SRC_RDY = 1'b0; RX_DATA = '0; RX_SOF = 1'b0; RX_EOF = 1'b0;
    RX_SOF_POS = '0; RX_EOF_POS = '0; RX_PORT = '0; TX_DST_RDY = 1'b1;
`ifdef ETH_TX_HDR_BUILDER_STATS_EN
    STAT_CLR = 1'b0;
`endif
    repeat (3) @(posedge CLK);
    #1;
    check("rst_rx_dst_rdy", DW'(RX_DST_RDY), '0);
    check("rst_tx_src_rdy", DW'(TX_SRC_RDY), '0);
    check("rst_tx_sof", DW'(TX_SOF), '0);
    check("rst_tx_eof", DW'(TX_EOF), '0);
    check("rst_tx_hdr", DW'(TX_HDR), '0);

    fork
      begin
        exp_t e;
        forever begin
          @(negedge CLK);
          if (RESET_N && TX_SRC_RDY && TX_DST_RDY) begin
            if (exp_q.size() == 0) begin
              n_vec++; n_err++;
              $error("FAIL unexpected_word: observed sof=%0b eof=%0b expected no word",
                     TX_SOF, TX_EOF);
            end else begin
              e = exp_q.pop_front();
              check("tx_data", TX_DATA, e.data);
              check("tx_sof_eof", DW'({TX_SOF, TX_EOF}), DW'({e.sof, e.eof}));
              if (e.sof) begin
                check("tx_sof_pos", DW'(TX_SOF_POS), DW'(e.sp));
                check("tx_hdr", DW'(TX_HDR), DW'(e.hdr));
              end
              if (e.eof) check("tx_eof_pos", DW'(TX_EOF_POS), DW'(e.ep));
            end
          end
        end
      end
    join_none

    RESET_N = 1'b1;
    @(posedge CLK); #1;

    // Single-word frame and its input-EOF to TX_SOF latency
    send_frame(64, 0, 8'd3);
    check("lat_not_yet", DW'(TX_SRC_RDY), '0);
    @(posedge CLK); #1;
    check("lat_src_rdy", DW'(TX_SRC_RDY), DW'(1));
    check("lat_sof", DW'(TX_SOF), DW'(1));
    check("lat_hdr", DW'(TX_HDR), DW'({1'b0, 8'd3, 16'd64}));
    wait_drain("single");

    send_frame(25, 2, 8'd7);
    wait_drain("runt");

    send_frame(16383, 0, 8'd1);
    send_frame(16448, 0, 8'd2);
    send_frame(100, 1, 8'd9);
    wait_drain("mtu");

    // Header FIFO fills with the output stalled
    TX_DST_RDY = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sb  = int'($urandom_range(7));
      len = int'($urandom_range(64 - sb * 8, 1));
      send_frame(len, sb, 8'(i));
    end
    repeat (3) @(posedge CLK);
    #1;
    check("hdr_full_rx_dst_rdy", DW'(RX_DST_RDY), '0);
    check("hdr_full_tx_src_rdy", DW'(TX_SRC_RDY), DW'(1));
    wait_drain("backpressure");

    gaps_en = 1'b1;
    rand_bp = 1'b1;
    for (int i = 0; i < 30; i++) begin
      sb  = int'($urandom_range(7));
      len = int'($urandom_range(400, 1));
      send_frame(len, sb, 8'($urandom));
    end
    rand_bp = 1'b0;
    gaps_en = 1'b0;
    wait_drain("random");

    // Reset in the middle of a frame
    send_word(rnd512(), 1'b1, 1'b0, 3'd0, 6'd0, 8'd4);
    send_word(rnd512(), 1'b0, 1'b0, 3'd0, 6'd0, 8'd4);
    send_word(rnd512(), 1'b0, 1'b0, 3'd0, 6'd0, 8'd4);
    RESET_N = 1'b0;
    #1;
    check("midrst_rx_dst_rdy", DW'(RX_DST_RDY), '0);
    check("midrst_tx_src_rdy", DW'(TX_SRC_RDY), '0);
    check("midrst_tx_sof", DW'(TX_SOF), '0);
    check("midrst_tx_hdr", DW'(TX_HDR), '0);
    repeat (2) @(posedge CLK);
    #1;
    RESET_N = 1'b1;
    repeat (10) @(posedge CLK);
    #1;
    check("post_rst_idle", DW'(TX_SRC_RDY), '0);
    send_frame(130, 3, 8'h5a);
    wait_drain("post_rst");

`ifdef ETH_TX_HDR_BUILDER_STATS_EN
    STAT_CLR = 1'b1;
    @(posedge CLK); #1;
    STAT_CLR = 1'b0;
    send_frame(100, 0, 8'd1);
    send_frame(30, 0, 8'd2);
    send_frame(64, 0, 8'd3);
    send_frame(10, 0, 8'd4);
    send_frame(200, 0, 8'd5);
    wait_drain("stats");
    check("stat_frames", DW'(STAT_FRAMES), DW'(5));
    check("stat_discards", DW'(STAT_DISCARDS), DW'(2));
    STAT_CLR = 1'b1;
    @(posedge CLK); #1;
    STAT_CLR = 1'b0;
    check("stat_frames_clr", DW'(STAT_FRAMES), '0);
    check("stat_discards_clr", DW'(STAT_DISCARDS), '0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/eth_tx_hdr_builder.md
Name: eth_tx_hdr_builder

Overview:
- Store-and-forward block on the user-to-network TX path, in front of the network module's per-port TX MFB input.
- Buffers each single-region MFB frame, measures its byte length and builds the 25-bit ETH TX header: length[15:0], port[23:16], discard[24].
- Releases the header together with the frame's SOF word once the whole frame is buffered.
- Counterpart of the RX path, which produces headers the application consumes; here the block produces the header the network module consumes.

Parameters:
- REGION_SIZE, 8, blocks per word (single region only)
- BLOCK_SIZE, 8, items per block
- ITEM_WIDTH, 8, bits per item (byte)
- TX_MTU, 16383, maximum accepted frame length in bytes
- LEN_MIN, 60, minimum accepted frame length in bytes
- DATA_DEPTH, 512, data FIFO depth in words; must satisfy DATA_DEPTH*WB >= TX_MTU+2*WB, where WB = REGION_SIZE*BLOCK_SIZE
- HDR_DEPTH, 16, header FIFO depth in entries

Ports:
- CLK  in  1  clock
- RESET_N  in  1  asynchronous active-low reset
- RX_DATA  in  WB*ITEM_WIDTH  frame data
- RX_SOF_POS  in  log2(REGION_SIZE)  SOF block index
- RX_EOF_POS  in  log2(WB)  EOF byte index
- RX_SOF  in  1  start of frame in word
- RX_EOF  in  1  end of frame in word
- RX_PORT  in  8  destination port, sampled at SOF
- RX_SRC_RDY  in  1  input valid
- RX_DST_RDY  out  1  input ready
- TX_DATA  out  WB*ITEM_WIDTH  data
- TX_SOF_POS  out  log2(REGION_SIZE)  SOF block index
- TX_EOF_POS  out  log2(WB)  EOF byte index
- TX_SOF  out  1  start of frame
- TX_EOF  out  1  end of frame
- TX_HDR  out  25  {discard, port, length}, valid when TX_SOF=1
- TX_SRC_RDY  out  1  output valid
- TX_DST_RDY  in  1  output ready

Behaviour:
- Clock and reset: one clock CLK; asynchronous active-low reset RESET_N.
- Reset values: RX_DST_RDY=0, TX_SRC_RDY=0, TX_SOF=0, TX_EOF=0, TX_HDR=0, both FIFOs empty, input FSM in IDLE.
- Input constraint: at most one SOF and one EOF per word; SOF after EOF in the same word is illegal.
- Handshake: a word transfers when SRC_RDY && DST_RDY. Neither interface's SRC_RDY drops or its data changes while DST_RDY=0.
- RX_DST_RDY = !data_full && !hdr_full. It is also 1 while the FSM is in DROP state, even if data FIFO is full.
- Input FSM states: IDLE, FRAME, DROP.
  - IDLE: a word with SOF starts a frame. acc = WB - SOF_POS*BLOCK_SIZE; port latched.
  - SOF+EOF in the same word: length = EOF_POS - SOF_POS*BLOCK_SIZE + 1; header pushed in the same cycle; stay in IDLE.
  - SOF without EOF: go to FRAME. Words without SOF in IDLE are ignored.
  - FRAME, middle word: acc += WB.
  - FRAME, EOF word: length = acc + EOF_POS + 1; header pushed; go to IDLE.
  - FRAME to DROP: taken if accepting the word would make acc exceed TX_MTU. The word is written with EOF forced to 1 at EOF_POS=WB-1, and the header is pushed with length=acc+WB (capped at 0xFFFF) and discard=1.
  - DROP: consumes input words without writing until the EOF word, then returns to IDLE.
- Arithmetic: acc is 17 bits, saturating; the header length field is the lower 16 bits, capped at 0xFFFF. discard=1 if length < LEN_MIN or the frame was truncated.
- Output side:
  - TX_SRC_RDY = data FIFO non-empty && (the word is not SOF, or the header FIFO is non-empty).
  - The header pops on the SOF word transfer; TX_HDR comes from the header FIFO head.
  - The data word at the FIFO head is presented combinationally (FWFT).
  - Minimum latency from input EOF transfer to TX_SOF valid: 2 cycles.
- Simultaneous push/pop on a full FIFO is permitted only when a pop occurs; RX_DST_RDY uses registered full flags and does not look at the pop.
- Reset mid-frame: all state is cleared; partial frames are lost; no TX word is emitted after reset deasserts until a new complete frame arrives.

Optional Feature:
- Macro: ETH_TX_HDR_BUILDER_STATS_EN.
- With the macro defined:
  - Adds outputs STAT_FRAMES (32 bits), STAT_DISCARDS (32 bits) and input STAT_CLR (1 bit).
  - Both counters count headers pushed (STAT_DISCARDS only when discard=1); both saturate at 2^32-1.
  - STAT_CLR synchronously zeroes both counters, with priority over increment.
  - Counters reset to 0.
- Without the macro: none of these ports or counters exist.

Test Plan:
- Single-word frame: SOF_POS=0, EOF_POS=63, port 3 -> TX_HDR length=64, port=3, discard=0; output 2 cycles after input EOF.
- Runt frame: SOF_POS=2, EOF_POS=40 -> length=25, discard=1; data forwarded unchanged.
- Frame of 16383 bytes -> length=16383, discard=0. Frame of 16448 bytes -> truncated at 16384 bytes, EOF forced, discard=1, remaining input consumed, next frame unaffected.
- Backpressure: TX_DST_RDY=0 while 16 short frames are sent -> header FIFO full, RX_DST_RDY=0. Releasing TX_DST_RDY -> all 16 frames out in order with correct headers.
- RESET_N asserted mid-frame after 3 words -> outputs at reset values; next full frame emitted correctly with no residue.
- Macro defined: 5 frames, 2 of them runts -> STAT_FRAMES=5, STAT_DISCARDS=2; STAT_CLR -> both 0.
